ks_control_fsm: RTL and testbench

KS_CONTROL_FSM -- requirements
Module: ks_control_fsm

---
 rtl/k_and_s_pkg.sv | 58 +++++
 rtl/ks_wait_counter.sv | 26 ++
 rtl/ks_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_ks_control_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S control unit: decoded instruction codes,
// control FSM states and ALU operation encodings.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_ADD    = 4'd1,
      I_SUB    = 4'd2,
      I_AND    = 4'd3,
      I_OR     = 4'd4,
      I_MOVE   = 4'd5,
      I_LOAD   = 4'd6,
      I_STORE  = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNZERO = 4'd10,
      I_BNEG   = 4'd11,
      I_BNNEG  = 4'd12,
      I_BOV    = 4'd13,
      I_BNOV   = 4'd14,
      I_HALT   = 4'd15
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_FETCH_WAIT = 4'd1,
      S_LATCH_IR   = 4'd2,
      S_DECODE     = 4'd3,
      S_EXEC_ALU   = 4'd4,
      S_LOAD_WAIT  = 4'd5,
      S_LOAD_WB    = 4'd6,
      S_STORE      = 4'd7,
      S_BRANCH     = 4'd8,
      S_HALT       = 4'd9
   } state_t;

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // ALU operation for an arithmetic/logic instruction; MOVE passes through as OR.
   function automatic logic [1:0] alu_op(input decoded_instruction_type ins);
      case (ins)
         I_ADD:   alu_op = OP_ADD;
         I_SUB:   alu_op = OP_SUB;
         I_AND:   alu_op = OP_AND;
         default: alu_op = OP_OR;
      endcase
   endfunction

   // True for instructions whose result updates the datapath flags.
   function automatic logic updates_flags(input decoded_instruction_type ins);
      updates_flags = (ins == I_ADD) || (ins == I_SUB) ||
                      (ins == I_AND) || (ins == I_OR);
   endfunction

endpackage

// File: rtl/ks_wait_counter.sv
// Memory wait-state counter: loadable, counts down to zero and holds there.
module ks_wait_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt;

   // Load takes priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/ks_control_fsm.sv
// Multi-cycle control FSM for the K-and-S processor: fetch, decode and
// execute sequencing, memory wait states, single-step and retire count.
module ks_control_fsm
   import k_and_s_pkg::*;
#(
   parameter int unsigned MEM_WAIT  = 0,
   parameter bit          OV_SIGNED = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   input  logic                    step_mode,
   input  logic                    step_req,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    write_reg_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic [1:0]              operation,
   output logic                    halt,
   output logic [CNT_W-1:0]        retired
);

   localparam bit          HAS_WAIT  = (MEM_WAIT > 0);
   localparam int unsigned WAIT_INI  = HAS_WAIT ? (MEM_WAIT - 1) : 0;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_INI);

   state_t state, state_n;
   logic   cnt_load, cnt_dec, cnt_zero;
   logic   ret_inc;
   logic   ov_flag;
   logic   cond_taken;

   assign ov_flag = OV_SIGNED ? signed_overflow : unsigned_overflow;

   ks_wait_counter u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register; reset returns to FETCH so all outputs drop at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         state <= state_n;
      end
   end

   // Retired-instruction counter, wraps naturally at its width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (ret_inc) begin
         retired <= retired + CNT_W'(1);
      end
   end

   // Branch condition evaluation on the flags presented during DECODE.
   always_comb begin
      cond_taken = 1'b0;
      case (decoded_instruction)
         I_BZERO:  cond_taken = zero_op;
         I_BNZERO: cond_taken = !zero_op;
         I_BNEG:   cond_taken = neg_op;
         I_BNNEG:  cond_taken = !neg_op;
         I_BOV:    cond_taken = ov_flag;
         I_BNOV:   cond_taken = !ov_flag;
         default:  cond_taken = 1'b0;
      endcase
   end

   // Next-state, datapath controls and retire strobe.
   always_comb begin
      state_n          = state;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      write_reg_enable = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      operation        = OP_OR;
      halt             = 1'b0;
      cnt_load         = 1'b0;
      cnt_dec          = 1'b0;

      case (state)
         S_FETCH: begin
            if (!(step_mode && !step_req)) begin
               if (HAS_WAIT) begin
                  state_n  = S_FETCH_WAIT;
                  cnt_load = 1'b1;
               end else begin
                  state_n = S_LATCH_IR;
               end
            end
         end
         S_FETCH_WAIT: begin
            if (cnt_zero) state_n = S_LATCH_IR;
            else          cnt_dec = 1'b1;
         end
         S_LATCH_IR: begin
            ir_enable = 1'b1;
            pc_enable = 1'b1;
            state_n   = S_DECODE;
         end
         S_DECODE: begin
            case (decoded_instruction)
               I_ADD, I_SUB, I_AND, I_OR, I_MOVE: state_n = S_EXEC_ALU;
               I_LOAD: begin
                  addr_sel = 1'b1;
                  if (HAS_WAIT) begin
                     state_n  = S_LOAD_WAIT;
                     cnt_load = 1'b1;
                  end else begin
                     state_n = S_LOAD_WB;
                  end
               end
               I_STORE: begin
                  addr_sel = 1'b1;
                  state_n  = S_STORE;
               end
               I_BRANCH: state_n = S_BRANCH;
               I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                  state_n = cond_taken ? S_BRANCH : S_FETCH;
               I_HALT:  state_n = S_HALT;
               default: state_n = S_FETCH;
            endcase
         end
         S_EXEC_ALU: begin
            write_reg_enable = 1'b1;
            c_sel            = 1'b1;
            operation        = alu_op(decoded_instruction);
            flags_reg_enable = updates_flags(decoded_instruction);
            state_n          = S_FETCH;
         end
         S_LOAD_WAIT: begin
            addr_sel = 1'b1;
            if (cnt_zero) state_n = S_LOAD_WB;
            else          cnt_dec = 1'b1;
         end
         S_LOAD_WB: begin
            addr_sel         = 1'b1;
            write_reg_enable = 1'b1;
            state_n          = S_FETCH;
         end
         S_STORE: begin
            addr_sel         = 1'b1;
            ram_write_enable = 1'b1;
            state_n          = S_FETCH;
         end
         S_BRANCH: begin
            branch    = 1'b1;
            pc_enable = 1'b1;
            state_n   = S_FETCH;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         default: state_n = S_FETCH;
      endcase

      ret_inc = ((state_n == S_FETCH) &&
                 ((state == S_EXEC_ALU) || (state == S_LOAD_WB) ||
                  (state == S_STORE) || (state == S_BRANCH) ||
                  (state == S_DECODE))) ||
                ((state_n == S_HALT) && (state != S_HALT));
   end

endmodule

// File: tb/tb_ks_control_fsm.sv
// Bench for ks_control_fsm: two instances (no wait states / signed overflow
// with a 16-bit counter, and two wait states / unsigned overflow with a 4-bit
// counter) exercised one after the other against a per-instruction
// output-trace model.
module tb_ks_control_fsm;
   import k_and_s_pkg::*;

   // Output vector bit positions
   localparam logic [10:0] O_BR = 11'h400;
   localparam logic [10:0] O_PC = 11'h200;
   localparam logic [10:0] O_IR = 11'h100;
   localparam logic [10:0] O_WR = 11'h080;
   localparam logic [10:0] O_AS = 11'h040;
   localparam logic [10:0] O_CS = 11'h020;
   localparam logic [10:0] O_FL = 11'h010;
   localparam logic [10:0] O_RW = 11'h008;
   localparam logic [10:0] O_HT = 11'h001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_n_v, zero_v, neg_v, uo_v, so_v, sm_v, sr_v;
   decoded_instruction_type instr_v [2];

   logic br0, pc0, ir0, wr0, as0, cs0, fl0, rw0, ht0;
   logic br1, pc1, ir1, wr1, as1, cs1, fl1, rw1, ht1;
   logic [1:0] op0, op1;
   logic [15:0] ret0;
   logic [3:0]  ret1;

   ks_control_fsm #(.MEM_WAIT(0), .OV_SIGNED(1'b1), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n_v[0]), .decoded_instruction(instr_v[0]),
      .zero_op(zero_v[0]), .neg_op(neg_v[0]), .unsigned_overflow(uo_v[0]),
      .signed_overflow(so_v[0]), .step_mode(sm_v[0]), .step_req(sr_v[0]),
      .branch(br0), .pc_enable(pc0), .ir_enable(ir0), .write_reg_enable(wr0),
      .addr_sel(as0), .c_sel(cs0), .flags_reg_enable(fl0), .ram_write_enable(rw0),
      .operation(op0), .halt(ht0), .retired(ret0));

   ks_control_fsm #(.MEM_WAIT(2), .OV_SIGNED(1'b0), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n_v[1]), .decoded_instruction(instr_v[1]),
      .zero_op(zero_v[1]), .neg_op(neg_v[1]), .unsigned_overflow(uo_v[1]),
      .signed_overflow(so_v[1]), .step_mode(sm_v[1]), .step_req(sr_v[1]),
      .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .write_reg_enable(wr1),
      .addr_sel(as1), .c_sel(cs1), .flags_reg_enable(fl1), .ram_write_enable(rw1),
      .operation(op1), .halt(ht1), .retired(ret1));

   int checks = 0;
   int failures = 0;
   int cur = 0;
   int ret_model = 0;
   logic [10:0] exp_tr [0:31];

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic bit ovs_of(input int d);
      return (d == 0);
   endfunction

   function automatic int mask_of(input int d);
      return (d == 0) ? 16'hFFFF : 4'hF;
   endfunction

   function automatic logic [10:0] obs_of(input int d);
      if (d == 0) return {br0, pc0, ir0, wr0, as0, cs0, fl0, rw0, op0, ht0};
      return {br1, pc1, ir1, wr1, as1, cs1, fl1, rw1, op1, ht1};
   endfunction

   function automatic int ret_of(input int d);
      return (d == 0) ? int'(ret0) : int'(ret1);
   endfunction

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, cur, act, exp);
      end
   endtask

   // Reference: whether a conditional branch is taken from its flag rule
   function automatic bit taken(input decoded_instruction_type ins,
                                input bit z, input bit n, input bit so, input bit uo);
      bit ov;
      ov = ovs_of(cur) ? so : uo;
      case (ins)
         I_BZERO:  return z;
         I_BNZERO: return !z;
         I_BNEG:   return n;
         I_BNNEG:  return !n;
         I_BOV:    return ov;
         I_BNOV:   return !ov;
         I_BRANCH: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Reference: cycle-by-cycle output trace of one instruction, from FETCH
   // up to (not including) the following FETCH / HALT.
   task automatic build_trace(input decoded_instruction_type ins,
                              input bit z, input bit n, input bit so, input bit uo,
                              output int len);
      int w;
      int k;
      w = wait_of(cur);
      k = 0;
      exp_tr[k] = '0; k++;
      for (int j = 0; j < w; j++) begin exp_tr[k] = '0; k++; end
      exp_tr[k] = O_IR | O_PC; k++;
      exp_tr[k] = (ins == I_LOAD || ins == I_STORE) ? O_AS : 11'h000; k++;
      case (ins)
         I_OR:   begin exp_tr[k] = O_WR | O_CS | O_FL | 11'h000; k++; end
         I_ADD:  begin exp_tr[k] = O_WR | O_CS | O_FL | 11'h002; k++; end
         I_SUB:  begin exp_tr[k] = O_WR | O_CS | O_FL | 11'h004; k++; end
         I_AND:  begin exp_tr[k] = O_WR | O_CS | O_FL | 11'h006; k++; end
         I_MOVE: begin exp_tr[k] = O_WR | O_CS; k++; end
         I_LOAD: begin
            for (int j = 0; j < w; j++) begin exp_tr[k] = O_AS; k++; end
            exp_tr[k] = O_AS | O_WR; k++;
         end
         I_STORE: begin exp_tr[k] = O_AS | O_RW; k++; end
         default: begin
            if (taken(ins, z, n, so, uo)) begin exp_tr[k] = O_BR | O_PC; k++; end
         end
      endcase
      len = k;
   endtask

   // Run one instruction starting at a FETCH cycle (called just after a
   // falling edge). stop_at >= 0 returns right after checking that cycle.
   task automatic run_instr(input decoded_instruction_type ins,
                            input bit z, input bit n, input bit so, input bit uo,
                            input bit use_step, input int stop_at, input int stray);
      int len;
      build_trace(ins, z, n, so, uo, len);
      instr_v[cur] = ins;
      zero_v[cur] = z; neg_v[cur] = n; so_v[cur] = so; uo_v[cur] = uo;
      sr_v[cur] = use_step;
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            @(negedge clk);
            sr_v[cur] = (i == stray);
         end
         #1;
         check($sformatf("trace_%s_c%0d", ins.name(), i), int'(obs_of(cur)), int'(exp_tr[i]));
         if (i == stop_at) return;
      end
      @(negedge clk);
      sr_v[cur] = 1'b0;
      #1;
      ret_model = (ret_model + 1) & mask_of(cur);
      check($sformatf("retired_%s", ins.name()), ret_of(cur), ret_model);
      if (ins == I_HALT) check("halt_entry", int'(obs_of(cur)), int'(O_HT));
   endtask

   initial begin
      int slen;
      rst_n_v = 2'b00; zero_v = '0; neg_v = '0; uo_v = '0; so_v = '0;
      sm_v = '0; sr_v = '0;
      instr_v[0] = I_NOP; instr_v[1] = I_NOP;

      for (int d = 0; d < 2; d++) begin
         cur = d;
         ret_model = 0;
         rst_n_v = 2'b00;
         repeat (3) @(negedge clk);
         #1;
         check("reset_outputs", int'(obs_of(cur)), 0);
         check("reset_retired", ret_of(cur), 0);
         rst_n_v[cur] = 1'b1;

         // Directed instruction mix
         run_instr(I_ADD,    0, 0, 0, 0, 0, -1, -1);
         run_instr(I_LOAD,   0, 0, 0, 0, 0, -1, -1);
         run_instr(I_STORE,  0, 0, 0, 0, 0, -1, -1);
         run_instr(I_BZERO,  0, 0, 0, 0, 0, -1, -1);
         run_instr(I_BZERO,  1, 0, 0, 0, 0, -1, -1);
         run_instr(I_BOV,    0, 0, 1, 0, 0, -1, -1);
         run_instr(I_BNOV,   0, 0, 1, 0, 0, -1, -1);
         run_instr(I_BNEG,   0, 1, 0, 1, 0, -1, -1);
         run_instr(I_SUB,    0, 0, 0, 0, 0, -1, -1);
         run_instr(I_MOVE,   1, 1, 1, 1, 0, -1, -1);
         run_instr(I_BRANCH, 0, 0, 0, 0, 0, -1, -1);
         run_instr(I_NOP,    0, 0, 0, 0, 0, -1, -1);

         // Random instructions and flags (retire counter of dut1 wraps)
         for (int k = 0; k < 40; k++) begin
            run_instr(decoded_instruction_type'($urandom_range(0, 14)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      0, -1, -1);
         end

         // Single-step: stall, one released instruction, stall again
         sm_v[cur] = 1'b1;
         for (int k = 0; k < 10; k++) begin
            check("stall_outputs", int'(obs_of(cur)), 0);
            check("stall_retired", ret_of(cur), ret_model);
            @(negedge clk); #1;
         end
         run_instr(I_AND, 0, 0, 0, 0, 1, -1, 2);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("stall_after_step", int'(obs_of(cur)), 0);
            check("stall_after_step_ret", ret_of(cur), ret_model);
         end
         sm_v[cur] = 1'b0;

         // HALT is absorbing; step_req pulses have no effect
         run_instr(I_HALT, 0, 0, 0, 0, 0, -1, -1);
         for (int k = 0; k < 5; k++) begin
            sr_v[cur] = k[0];
            @(negedge clk); #1;
            check("halt_hold", int'(obs_of(cur)), int'(O_HT));
            check("halt_retired", ret_of(cur), ret_model);
         end
         sr_v[cur] = 1'b0;
         rst_n_v[cur] = 1'b0;
         #1;
         check("halt_reset_outputs", int'(obs_of(cur)), 0);
         check("halt_reset_retired", ret_of(cur), 0);
         ret_model = 0;
         @(negedge clk);
         rst_n_v[cur] = 1'b1;
         run_instr(I_OR, 0, 0, 0, 0, 0, -1, -1);

         // Reset asserted in the STORE cycle
         build_trace(I_STORE, 0, 0, 0, 0, slen);
         run_instr(I_STORE, 0, 0, 0, 0, 0, slen - 1, -1);
         check("store_we_before_reset", int'(obs_of(cur) & O_RW), int'(O_RW));
         rst_n_v[cur] = 1'b0;
         #1;
         check("store_reset_outputs", int'(obs_of(cur)), 0);
         check("store_reset_retired", ret_of(cur), 0);
         ret_model = 0;
         @(negedge clk);
         rst_n_v[cur] = 1'b1;
         run_instr(I_ADD, 0, 0, 0, 0, 0, -1, -1);
         rst_n_v[cur] = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
